// File: rtl/pong_pkg.sv
// -----------------------------------------------------------------------------
// pong_pkg
// Shared definitions for the pong codebase: game-state and winner encodings
// (the ball block decodes the same state constants), VGA raster limits and
// common datapath widths.
// -----------------------------------------------------------------------------
package pong_pkg;

  // Game state as driven on the 2-bit state bus. Values are fixed because the
  // ball block decodes them directly.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_POINT = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  // Winner code as presented to the score display.
  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_P1   = 2'd1,
    WIN_P2   = 2'd2
  } winner_t;

  // Last column/row of the 800x525 VGA raster (visible area plus blanking).
  localparam int unsigned X_MAX = 799;
  localparam int unsigned Y_MAX = 524;

  // Datapath widths.
  localparam int unsigned COORD_W = 10;
  localparam int unsigned SCORE_W = 4;
  localparam int unsigned PAUSE_W = 8;

endpackage : pong_pkg

// File: rtl/game_ctrl_if.sv
// -----------------------------------------------------------------------------
// game_ctrl_if
// Bundle between the ball/paddle logic and the match controller.
//   score1, score2  : point levels from the ball block (synchronous to clk)
//   x, y            : current VGA pixel column / row
//   state           : game state (pong_pkg::state_t encoding)
//   p1_score        : player-1 points, binary
//   p2_score        : player-2 points, binary
//   winner          : pong_pkg::winner_t encoding
//   point_pulse     : one-cycle pulse per accepted point
// The controller takes the slave view; the ball/display side (or a bench)
// takes the master view.
// -----------------------------------------------------------------------------
interface game_ctrl_if;
  import pong_pkg::*;

  logic               score1;
  logic               score2;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic [1:0]         state;
  logic [SCORE_W-1:0] p1_score;
  logic [SCORE_W-1:0] p2_score;
  logic [1:0]         winner;
  logic               point_pulse;

  modport master (
    output score1, score2, x, y,
    input  state, p1_score, p2_score, winner, point_pulse
  );

  modport slave (
    input  score1, score2, x, y,
    output state, p1_score, p2_score, winner, point_pulse
  );

endinterface : game_ctrl_if

// File: rtl/game_ctrl_sync_edge.sv
// -----------------------------------------------------------------------------
// sync_edge
// Two-flop synchronizer followed by a registered rising-edge detector.
// A rise on din appears as a one-cycle pulse three clk edges later.
// Ports:
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   din     : asynchronous level input
//   pulse   : one-cycle pulse on each synchronized rising edge
// -----------------------------------------------------------------------------
module sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic pulse
);

  logic [1:0] sync_q;
  logic       prev_q;
  logic       pulse_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchronizer chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], din};
      prev_q  <= sync_q[1];
      pulse_q <= sync_q[1] & ~prev_q;
    end
  end

  assign pulse = pulse_q;

endmodule : sync_edge

// File: rtl/game_ctrl.sv
// -----------------------------------------------------------------------------
// game_ctrl
// Match controller. Synchronizes the start button, turns the ball block's
// score levels into single events, keeps per-player scores, holds a serve
// pause of PAUSE_FRAMES frame ticks after each point and declares a winner
// at WIN_SCORE. The only block that advances the game state.
// Parameters:
//   WIN_SCORE    : points needed to win (1..15)
//   PAUSE_FRAMES : frame ticks spent in POINT after a point (1..255)
//   TICK_Y/TICK_X: raster position that marks one frame tick
// Ports:
//   clk       : 100 MHz system clock
//   reset_n   : asynchronous active-low reset
//   start_btn : raw start button, asynchronous to clk
//   bus       : game_ctrl_if.slave (score levels, raster position in;
//               state, scores, winner, point_pulse out - all registered)
// -----------------------------------------------------------------------------
module game_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned PAUSE_FRAMES = 120,
  parameter int unsigned TICK_Y       = 481,
  parameter int unsigned TICK_X       = 0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start_btn,
  game_ctrl_if.slave   bus
);

  localparam logic [SCORE_W-1:0] WIN_Q   = SCORE_W'(WIN_SCORE);
  localparam logic [PAUSE_W-1:0] PAUSE_Q = PAUSE_W'(PAUSE_FRAMES);
  localparam logic [COORD_W-1:0] TY_Q    = COORD_W'(TICK_Y);
  localparam logic [COORD_W-1:0] TX_Q    = COORD_W'(TICK_X);

  // ---------------------------------------------------------------------------
  // Registers and their next values
  // ---------------------------------------------------------------------------
  state_t             state_q, state_d;
  logic [SCORE_W-1:0] p1_q, p1_d;
  logic [SCORE_W-1:0] p2_q, p2_d;
  winner_t            win_q, win_d;
  logic               pulse_q, pulse_d;
  logic [PAUSE_W-1:0] cnt_q, cnt_d;
  logic               prev1_q, prev2_q;

  // ---------------------------------------------------------------------------
  // Event sources
  // ---------------------------------------------------------------------------
  logic start_evt;

  sync_edge u_start_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (start_btn),
    .pulse   (start_evt)
  );

  logic frame_tick;
  assign frame_tick = (bus.y == TY_Q) && (bus.x == TX_Q);

  // Score levels are already synchronous; edge detect against last cycle.
  // prev registers track every cycle regardless of state, so a level that is
  // already high when PLAY is entered never counts.
  logic s1_evt, s2_evt;
  assign s1_evt = bus.score1 & ~prev1_q;
  assign s2_evt = bus.score2 & ~prev2_q;

  // Player 1 wins ties: a coincident player-2 event is dropped.
  logic hit1, hit2;
  assign hit1 = (state_q == ST_PLAY) && s1_evt;
  assign hit2 = (state_q == ST_PLAY) && !s1_evt && s2_evt;

  logic [SCORE_W-1:0] p1_inc, p2_inc;
  assign p1_inc = p1_q + SCORE_W'(1);
  assign p2_inc = p2_q + SCORE_W'(1);

  logic win_hit;
  assign win_hit = (hit1 && (p1_inc == WIN_Q)) || (hit2 && (p2_inc == WIN_Q));

  logic pause_done;
  assign pause_done = frame_tick && (cnt_q == PAUSE_W'(1));

  // ---------------------------------------------------------------------------
  // State register (also registers the datapath so all outputs are flops)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      p1_q    <= '0;
      p2_q    <= '0;
      win_q   <= WIN_NONE;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
      prev1_q <= 1'b0;
      prev2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      win_q   <= win_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
      prev1_q <= bus.score1;
      prev2_q <= bus.score2;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first so no path through
    // the case leaves it unassigned, which would infer a latch.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_evt)    state_d = ST_PLAY;
      ST_PLAY:  if (hit1 || hit2) state_d = win_hit ? ST_OVER : ST_POINT;
      ST_POINT: if (pause_done)   state_d = ST_PLAY;
      ST_OVER:  if (start_evt)    state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    p1_d    = p1_q;
    p2_d    = p2_q;
    win_d   = win_q;
    pulse_d = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        // Scores are cleared only on the way into PLAY, so the final result
        // stays visible through OVER and IDLE.
        if (start_evt) begin
          p1_d  = '0;
          p2_d  = '0;
          win_d = WIN_NONE;
        end
      end
      ST_PLAY: begin
        if (hit1) begin
          p1_d    = p1_inc;
          pulse_d = 1'b1;
          if (win_hit) win_d = WIN_P1;
          else         cnt_d = PAUSE_Q;
        end else if (hit2) begin
          p2_d    = p2_inc;
          pulse_d = 1'b1;
          if (win_hit) win_d = WIN_P2;
          else         cnt_d = PAUSE_Q;
        end
      end
      ST_POINT: begin
        if (frame_tick && (cnt_q != '0)) cnt_d = cnt_q - PAUSE_W'(1);
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.state       = state_q;
  assign bus.p1_score    = p1_q;
  assign bus.p2_score    = p2_q;
  assign bus.winner      = win_q;
  assign bus.point_pulse = pulse_q;

endmodule : game_ctrl

// File: tb/tb_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_game_ctrl
// Directed bench for game_ctrl. Inputs change 1 ns after a rising edge and
// outputs are sampled at that same point, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_game_ctrl;
  import pong_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  logic start_btn;

  game_ctrl_if bus ();

  game_ctrl #(
    .WIN_SCORE    (7),
    .PAUSE_FRAMES (120),
    .TICK_Y       (481),
    .TICK_X       (0)
  ) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start_btn (start_btn),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    else             n_pass++;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_raster();
    bus.x = 10'd100;
    bus.y = 10'd100;
  endtask

  // One frame tick cycle followed by one non-tick cycle.
  task automatic tick_frame();
    bus.x = 10'd0;
    bus.y = 10'd481;
    step(1);
    idle_raster();
    step(1);
  endtask

  // Full 120-tick serve pause: POINT after 119 ticks, PLAY after the 120th.
  task automatic run_pause();
    for (int i = 1; i <= 119; i++) tick_frame();
    check("pause_119", bus.state, ST_POINT);
    bus.x = 10'd0;
    bus.y = 10'd481;
    step(1);
    idle_raster();
    check("pause_120", bus.state, ST_PLAY);
  endtask

  task automatic press_start();
    start_btn = 1'b1;
    step(4);
    start_btn = 1'b0;
    step(3);
  endtask

  int pulses;

  initial begin
    reset_n    = 1'b0;
    start_btn  = 1'b0;
    bus.score1 = 1'b0;
    bus.score2 = 1'b0;
    idle_raster();
    step(2);
    check("rst_state",  bus.state,       ST_IDLE);
    check("rst_p1",     bus.p1_score,    0);
    check("rst_p2",     bus.p2_score,    0);
    check("rst_winner", bus.winner,      WIN_NONE);
    check("rst_pulse",  bus.point_pulse, 0);
    reset_n = 1'b1;
    step(1);

    // Start: state must flip exactly on the 4th edge after the rise.
    start_btn = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step(1);
      check("start_latency", bus.state, ST_IDLE);
    end
    step(1);
    check("start_play", bus.state, ST_PLAY);
    step(6);
    start_btn = 1'b0;
    step(3);
    check("start_p1", bus.p1_score, 0);
    check("start_p2", bus.p2_score, 0);
    check("start_hold", bus.state, ST_PLAY);

    // Long score1 level counts once.
    bus.score1 = 1'b1;
    step(1);
    check("pt1_p1",    bus.p1_score,    1);
    check("pt1_pulse", bus.point_pulse, 1);
    check("pt1_state", bus.state,       ST_POINT);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      pulses += int'(bus.point_pulse);
    end
    check("pt1_extra_pulses", pulses, 0);
    bus.score1 = 1'b0;
    step(1);

    // Pause with score2 activity (ignored) and near-miss tick positions.
    for (int i = 1; i <= 119; i++) begin
      bus.score2 = (i % 4 == 1);
      tick_frame();
    end
    check("pause_state_119", bus.state, ST_POINT);
    check("pause_p2_ign",    bus.p2_score, 0);
    bus.x = 10'd1;
    bus.y = 10'd481;
    step(1);
    bus.x = 10'd0;
    bus.y = 10'd480;
    step(1);
    idle_raster();
    step(1);
    check("near_tick", bus.state, ST_POINT);
    bus.x = 10'd0;
    bus.y = 10'd481;
    step(1);
    idle_raster();
    check("pause_done",  bus.state,    ST_PLAY);
    check("pause_p2",    bus.p2_score, 0);

    // Simultaneous events: player 1 wins the tie.
    bus.score1 = 1'b1;
    bus.score2 = 1'b1;
    step(1);
    check("tie_p1",    bus.p1_score,    2);
    check("tie_p2",    bus.p2_score,    0);
    check("tie_pulse", bus.point_pulse, 1);
    check("tie_state", bus.state,       ST_POINT);
    step(1);
    check("tie_pulse_end", bus.point_pulse, 0);
    bus.score1 = 1'b0;
    bus.score2 = 1'b0;
    run_pause();

    // Player 2 runs out the match.
    for (int k = 1; k <= 7; k++) begin
      bus.score2 = 1'b1;
      step(1);
      check("p2_run_score", bus.p2_score,    k);
      check("p2_run_pulse", bus.point_pulse, 1);
      bus.score2 = 1'b0;
      if (k < 7) begin
        check("p2_run_state",  bus.state,  ST_POINT);
        check("p2_run_winner", bus.winner, WIN_NONE);
        step(1);
        run_pause();
      end else begin
        check("win_state",  bus.state,    ST_OVER);
        check("win_winner", bus.winner,   WIN_P2);
        check("win_p1",     bus.p1_score, 2);
      end
    end

    // OVER ignores further points.
    step(1);
    bus.score1 = 1'b1;
    step(1);
    check("over_p1",    bus.p1_score,    2);
    check("over_pulse", bus.point_pulse, 0);
    bus.score1 = 1'b0;
    bus.score2 = 1'b1;
    step(1);
    check("over_p2",    bus.p2_score, 7);
    check("over_state", bus.state,    ST_OVER);
    bus.score2 = 1'b0;
    step(1);

    // OVER -> IDLE keeps the result; IDLE -> PLAY clears it.
    press_start();
    check("idle_state",  bus.state,    ST_IDLE);
    check("idle_p2",     bus.p2_score, 7);
    check("idle_winner", bus.winner,   WIN_P2);
    press_start();
    check("replay_state",  bus.state,    ST_PLAY);
    check("replay_p1",     bus.p1_score, 0);
    check("replay_p2",     bus.p2_score, 0);
    check("replay_winner", bus.winner,   WIN_NONE);

    // Reach p1=3 in POINT, then reset asynchronously mid-cycle.
    for (int k = 1; k <= 3; k++) begin
      bus.score1 = 1'b1;
      step(1);
      bus.score1 = 1'b0;
      step(1);
      if (k < 3) run_pause();
    end
    check("pre_rst_p1",    bus.p1_score, 3);
    check("pre_rst_state", bus.state,    ST_POINT);
    for (int i = 0; i < 5; i++) tick_frame();
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_state",  bus.state,       ST_IDLE);
    check("arst_p1",     bus.p1_score,    0);
    check("arst_p2",     bus.p2_score,    0);
    check("arst_winner", bus.winner,      WIN_NONE);
    check("arst_pulse",  bus.point_pulse, 0);
    step(2);
    check("arst_hold", bus.state, ST_IDLE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_game_ctrl
